// File: rtl/sensor_pkg.sv
// Shared constants and helpers for the sensor conditioner.
//   N_SENSORS_DEF : default channel count (S1..S6 -> bits 0..5)
//   DEBOUNCE_DEF  : default debounce length in synchronised cycles
//   ID_W          : event index width for the default channel count
//   lowest_set()  : index of the lowest set bit among the first n bits
package sensor_pkg;

  localparam int N_SENSORS_DEF = 6;
  localparam int DEBOUNCE_DEF  = 16;
  localparam int ID_W          = $clog2(N_SENSORS_DEF);

  // Returns 0 when no bit is set; callers qualify the result with their own "any" flag.
  function automatic int lowest_set(input logic [31:0] v, input int n);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (i < n && v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Event channel between the sensor conditioner and the train controller.
//   evt_valid   : an event is pending
//   evt_id      : index of the pending sensor, valid only while evt_valid
//   evt_ack     : consumer accepts the pending event
//   evt_overrun : sticky flag, at least one rise event was dropped
// Modports: master = conditioner (producer), slave = controller (consumer).
interface sensor_conditioner_if
  import sensor_pkg::*;
#(
  parameter int ID_W_P = ID_W
);
  logic              evt_valid;
  logic [ID_W_P-1:0] evt_id;
  logic              evt_ack;
  logic              evt_overrun;

  modport master (output evt_valid, output evt_id, output evt_overrun, input evt_ack);
  modport slave  (input evt_valid, input evt_id, input evt_overrun, output evt_ack);
endinterface

// File: rtl/sensor_debounce.sv
// One sensor channel: two-flop synchroniser, debounce counter, stable level
// and a registered rising-edge pulse.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_s_in         : raw asynchronous sensor level
//   o_stable       : debounced level
//   o_rise         : one-cycle pulse in the first cycle o_stable is 1
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_s_in,
  output logic o_stable,
  output logic o_rise
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             r_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_sync1 <= i_s_in;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_sync2;
        // Rise pulse coincides with the first cycle of the new stable high level.
        r_rise   <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_rise;
endmodule

// File: rtl/sensor_conditioner.sv
// Front end for the train controller: conditions the raw track sensors and
// presents one "train passed sensor N" event at a time.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_s_in         : raw sensor levels, active-high
//   o_s_stable     : debounced sensor levels
//   o_s_rise       : per-channel one-cycle pulse on stable 0->1
//   evt (master)   : valid/ack event channel with sticky overrun flag
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int N_SENSORS       = N_SENSORS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_SENSORS-1:0] i_s_in,
  output logic [N_SENSORS-1:0] o_s_stable,
  output logic [N_SENSORS-1:0] o_s_rise,
  sensor_conditioner_if.master evt
);
  localparam int ID_L = $clog2(N_SENSORS);

  logic [N_SENSORS-1:0] w_stable;
  logic [N_SENSORS-1:0] w_rise;
  logic                 w_rise_any;
  logic                 w_rise_multi;
  logic [ID_L-1:0]      w_sel;
  logic                 w_ack;
  logic                 w_ovr_set;

  logic                 r_valid;
  logic [ID_L-1:0]      r_id;
  logic                 r_overrun;

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_ch
    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_s_in  (i_s_in[g]),
      .o_stable(w_stable[g]),
      .o_rise  (w_rise[g])
    );
  end

  assign w_rise_any   = |w_rise;
  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign w_rise_multi = (w_rise & (w_rise - 1'b1)) != '0;
  assign w_sel        = ID_L'(lowest_set(32'(w_rise), N_SENSORS));
  assign w_ack        = evt.evt_ack && r_valid;
  // An event is lost if a rise arrives while one is pending and not being
  // accepted, or if several channels rise together (only the lowest is kept).
  assign w_ovr_set    = (r_valid && !w_ack && w_rise_any) || w_rise_multi;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_ack) begin
        if (w_rise_any) r_id    <= w_sel;
        else            r_valid <= 1'b0;
      end else if (!r_valid && w_rise_any) begin
        r_valid <= 1'b1;
        r_id    <= w_sel;
      end

      if (w_ovr_set)  r_overrun <= 1'b1;
      else if (w_ack) r_overrun <= 1'b0;
    end
  end

  assign o_s_stable      = w_stable;
  assign o_s_rise        = w_rise;
  assign evt.evt_valid   = r_valid;
  assign evt.evt_id      = r_id;
  assign evt.evt_overrun = r_overrun;
endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner. Expected events are queued when
// a sensor is driven and popped when the DUT presents EVT_VALID.
module tb_sensor_conditioner;
  import sensor_pkg::*;

  typedef struct packed {
    logic [2:0] id;
    logic       ovr;
  } exp_evt_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] s_in;
  logic [5:0] s_stable;
  logic [5:0] s_rise;

  exp_evt_t exp_q[$];
  int n_checks;
  int n_err;

  sensor_conditioner_if #(.ID_W_P(3)) evt ();

  sensor_conditioner #(
    .N_SENSORS      (6),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_s_in    (s_in),
    .o_s_stable(s_stable),
    .o_s_rise  (s_rise),
    .evt       (evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_event(input string tag, input int budget);
    exp_evt_t e;
    int k;
    k = 0;
    while (evt.evt_valid !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_valid"}, 32'(evt.evt_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      if (evt.evt_valid === 1'b1) begin
        chk({tag, "_id"}, 32'(evt.evt_id), 32'(e.id));
        chk({tag, "_ovr"}, 32'(evt.evt_overrun), 32'(e.ovr));
      end
    end
  endtask

  task automatic ack_once();
    evt.evt_ack = 1'b1;
    step(1);
    evt.evt_ack = 1'b0;
  endtask

  initial begin
    logic seen;
    n_checks    = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    s_in        = '0;
    evt.evt_ack = 1'b0;

    // Reset state
    step(3);
    chk("rst_out", {s_stable, s_rise, evt.evt_valid, evt.evt_overrun}, 32'd0);
    rst_n = 1'b1;
    step(3);

    // 1: hold S_IN[2]; stable on the 18th edge counting the first sampling edge
    s_in[2] = 1'b1;
    exp_q.push_back('{id: 3'd2, ovr: 1'b0});
    step(17);
    chk("t1_stable_early", 32'(s_stable), 32'h00);
    step(1);
    chk("t1_stable", 32'(s_stable), 32'h04);
    chk("t1_rise", 32'(s_rise), 32'h04);
    chk("t1_valid_early", 32'(evt.evt_valid), 32'd0);
    step(1);
    chk("t1_rise_gone", 32'(s_rise), 32'h00);
    wait_event("t1_evt", 0);
    ack_once();
    chk("t1_ack_valid", 32'(evt.evt_valid), 32'd0);
    s_in[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step(1);
      seen = seen | (|s_rise) | evt.evt_valid;
    end
    chk("t1_fall_noevt", 32'(seen), 32'd0);
    chk("t1_fall_stable", 32'(s_stable), 32'h00);

    // 2: 10-cycle glitch is rejected, 16-cycle pulse is accepted
    s_in[0] = 1'b1;
    step(10);
    s_in[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      seen = seen | (|s_stable) | (|s_rise) | evt.evt_valid;
    end
    chk("t2_glitch", 32'(seen), 32'd0);
    s_in[0] = 1'b1;
    exp_q.push_back('{id: 3'd0, ovr: 1'b0});
    step(16);
    s_in[0] = 1'b0;
    wait_event("t2_evt", 40);
    ack_once();
    step(25);
    chk("t2_settle", {s_stable, evt.evt_valid}, 32'd0);

    // 3: simultaneous rises on 4 and 1
    s_in[4] = 1'b1;
    s_in[1] = 1'b1;
    exp_q.push_back('{id: 3'd1, ovr: 1'b1});
    wait_event("t3_evt", 40);
    ack_once();
    chk("t3_ack", {evt.evt_valid, evt.evt_overrun}, 32'd0);
    s_in[4] = 1'b0;
    s_in[1] = 1'b0;
    step(25);

    // 4: pending ID 3, dropped rise on 5, then ack coincident with rise on 0
    s_in[3] = 1'b1;
    exp_q.push_back('{id: 3'd3, ovr: 1'b0});
    wait_event("t4_evt", 40);
    s_in[5] = 1'b1;
    step(20);
    chk("t4_hold", {evt.evt_valid, 1'b0, evt.evt_id, evt.evt_overrun}, {27'd0, 1'b1, 1'b0, 3'd3, 1'b1});
    s_in[0] = 1'b1;
    exp_q.push_back('{id: 3'd0, ovr: 1'b0});
    step(18);
    chk("t4_rise0", 32'(s_rise), 32'h01);
    ack_once();
    wait_event("t4_reload", 0);
    ack_once();
    s_in = '0;
    step(25);
    chk("t4_clear", {evt.evt_valid, evt.evt_overrun}, 32'd0);

    // 5: async reset mid-debounce with an event pending
    s_in[1] = 1'b1;
    exp_q.push_back('{id: 3'd1, ovr: 1'b0});
    wait_event("t5_pre", 40);
    s_in[3] = 1'b1;
    step(10);
    chk("t5_pre_stable", 32'(s_stable), 32'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async", {s_stable, s_rise, evt.evt_valid, evt.evt_id, evt.evt_overrun}, 32'd0);
    step(2);
    rst_n = 1'b1;
    exp_q.push_back('{id: 3'd1, ovr: 1'b1});
    step(17);
    chk("t5_relearn_early", 32'(s_stable), 32'h00);
    step(1);
    chk("t5_relearn", 32'(s_rise), 32'h0A);
    step(1);
    wait_event("t5_evt", 0);
    ack_once();
    chk("t5_ack", {evt.evt_valid, evt.evt_overrun}, 32'd0);

    // 6: ack with nothing pending has no effect
    evt.evt_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t6_idle_ack", {s_stable, s_rise, evt.evt_valid, evt.evt_overrun}, {18'd0, 6'h0A, 6'h00, 2'b00});
    end
    evt.evt_ack = 1'b0;

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
